// File: rtl/qtr_pkg.sv
// Shared widths, channel state encoding and default timing for the QTR-8RC sensor emulator.
package qtr_pkg;

   localparam int VAL_W          = 8;
   localparam int CYC_W          = 16;
   localparam int CH_N           = 8;
   localparam int DEF_TICK_DIV   = 50;
   localparam int DEF_CHARGE_MIN = 10;
   localparam int DEF_HOLDOFF    = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CHARGE  = 2'd1;
   localparam logic [1:0] ST_DECAY   = 2'd2;
   localparam logic [1:0] ST_HOLDOFF = 2'd3;

   function automatic logic [CYC_W-1:0] decay_cycles(input logic [VAL_W-1:0] v, input int div);
      return CYC_W'(v) * CYC_W'(div);
   endfunction

endpackage

// File: rtl/qtr_rc_emulator_if.sv
// Bus between the test equipment (master) and the emulator (slave): config, pad values, status.
interface qtr_rc_emulator_if;
   import qtr_pkg::*;

   logic             en;
   logic             load;
   logic [VAL_W-1:0] V8, V7, V6, V5, V4, V3, V2, V1;
   logic [CH_N-1:0]  D_i;
   logic [CH_N-1:0]  D_o;
   logic [CH_N-1:0]  D_oe;
   logic [CH_N-1:0]  busy;
   logic [CH_N-1:0]  done;
   logic             tick;

   modport master (
      output en, load, V8, V7, V6, V5, V4, V3, V2, V1, D_i,
      input  D_o, D_oe, busy, done, tick
   );

   modport slave (
      input  en, load, V8, V7, V6, V5, V4, V3, V2, V1, D_i,
      output D_o, D_oe, busy, done, tick
   );

endinterface

// File: rtl/qtr_rc_tx.sv
// One emulated sensor line: pad synchroniser plus the charge-detect / decay / holdoff FSM.
//   state      | meaning
//   ST_IDLE    | line released, waiting for reader charge pulse
//   ST_CHARGE  | pad high, counting toward charge qualification
//   ST_DECAY   | emulator drives line high for the programmed time
//   ST_HOLDOFF | line released, waiting for a quiet low period before re-arming
module qtr_rc_tx import qtr_pkg::*; #(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int CHARGE_MIN = DEF_CHARGE_MIN,
   parameter int HOLDOFF    = DEF_HOLDOFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pad,
   input  logic [VAL_W-1:0] val,
   output logic             drive,
   output logic             oe,
   output logic             busy,
   output logic             done
);

   logic [1:0]       sync;
   logic [1:0]       state;
   logic [7:0]       hcnt;
   logic [7:0]       lcnt;
   logic [CYC_W-1:0] cnt;
   logic             done_r;
   logic             s;

   assign s = sync[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync   <= '0;
         state  <= ST_IDLE;
         hcnt   <= '0;
         lcnt   <= '0;
         cnt    <= '0;
         done_r <= 1'b0;
      end else begin
         sync   <= {sync[0], pad};
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s && en) begin
                  state <= ST_CHARGE;
                  hcnt  <= 8'd1;
               end
            end
            ST_CHARGE: begin
               if (!en) begin
                  state <= ST_IDLE;
               end else if (hcnt == 8'(CHARGE_MIN)) begin
                  state <= ST_DECAY;
                  cnt   <= decay_cycles(val, TICK_DIV);
               end else if (!s) begin
                  state <= ST_IDLE;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            ST_DECAY: begin
               // cnt<=1 exits: N cycles of DECAY for N>0, and one cycle for V=0
               if (cnt <= CYC_W'(1)) begin
                  state  <= ST_HOLDOFF;
                  done_r <= 1'b1;
                  lcnt   <= '0;
               end else begin
                  cnt <= cnt - CYC_W'(1);
               end
            end
            ST_HOLDOFF: begin
               if (s) begin
                  lcnt <= '0;
               end else if (lcnt == 8'(HOLDOFF - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  lcnt <= lcnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign oe    = (state == ST_DECAY);
   assign drive = oe;
   assign busy  = (state == ST_CHARGE) || (state == ST_DECAY);
   assign done  = done_r;

endmodule

// File: rtl/qtr_rc_emulator.sv
// Eight-channel QTR-8RC emulator top: shadow value registers, shared tick prescaler, channel array.
module qtr_rc_emulator import qtr_pkg::*; #(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int CHARGE_MIN = DEF_CHARGE_MIN,
   parameter int HOLDOFF    = DEF_HOLDOFF
) (
   input logic               clk,
   input logic               rst,
   qtr_rc_emulator_if.slave  bus
);

   logic [VAL_W-1:0] shadow [CH_N];
   logic [CYC_W-1:0] pre;
   logic [CH_N-1:0]  drive;
   logic [CH_N-1:0]  oe;
   logic [CH_N-1:0]  busy;
   logic [CH_N-1:0]  done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CH_N; i++) shadow[i] <= '0;
         pre <= '0;
      end else begin
         if (bus.load) begin
            shadow[0] <= bus.V1;
            shadow[1] <= bus.V2;
            shadow[2] <= bus.V3;
            shadow[3] <= bus.V4;
            shadow[4] <= bus.V5;
            shadow[5] <= bus.V6;
            shadow[6] <= bus.V7;
            shadow[7] <= bus.V8;
         end
         pre <= (pre == CYC_W'(TICK_DIV - 1)) ? '0 : pre + CYC_W'(1);
      end
   end

   // Decay timing is cycle-exact per channel; tick is a shared time-base strobe for observers.
   assign bus.tick = (pre == CYC_W'(TICK_DIV - 1));

   for (genvar i = 0; i < CH_N; i++) begin : g_ch
      qtr_rc_tx #(
         .TICK_DIV   (TICK_DIV),
         .CHARGE_MIN (CHARGE_MIN),
         .HOLDOFF    (HOLDOFF)
      ) u_tx (
         .clk   (clk),
         .rst   (rst),
         .en    (bus.en),
         .pad   (bus.D_i[i]),
         .val   (shadow[i]),
         .drive (drive[i]),
         .oe    (oe[i]),
         .busy  (busy[i]),
         .done  (done[i])
      );
   end

   assign bus.D_o  = drive;
   assign bus.D_oe = oe;
   assign bus.busy = busy;
   assign bus.done = done;

endmodule

// File: tb/tb_qtr_rc_emulator.sv
// Directed bench for the QTR-8RC emulator: latency, decay length, glitch rejection, shadow and reset behaviour.
module tb_qtr_rc_emulator;
   import qtr_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   q, nt, len, npulse;
   int   at [8];

   qtr_rc_emulator_if bus ();

   qtr_rc_emulator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_v(input logic [7:0] v8, input logic [7:0] v7, input logic [7:0] v6,
                         input logic [7:0] v5, input logic [7:0] v4, input logic [7:0] v3,
                         input logic [7:0] v2, input logic [7:0] v1);
      bus.V8 = v8; bus.V7 = v7; bus.V6 = v6; bus.V5 = v5;
      bus.V4 = v4; bus.V3 = v3; bus.V2 = v2; bus.V1 = v1;
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] mask, input int n);
      bus.D_i = mask;
      repeat (n) step();
      bus.D_i = '0;
   endtask

   task automatic run_len(input int ch, input int init, input int limit, output int n);
      n = init;
      while (bus.D_oe[ch] && n < limit) begin
         n++;
         step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en = 1'b1; bus.load = 1'b0; bus.D_i = '0;
      bus.V8 = '0; bus.V7 = '0; bus.V6 = '0; bus.V5 = '0;
      bus.V4 = '0; bus.V3 = '0; bus.V2 = '0; bus.V1 = '0;
      rst = 1'b0;
      repeat (3) step();
      check("rst_oe",   bus.D_oe, 8'h00);
      check("rst_do",   bus.D_o,  8'h00);
      check("rst_busy", bus.busy, 8'h00);
      check("rst_done", bus.done, 8'h00);
      rst = 1'b1;

      q = 0; nt = 0;
      repeat (100) begin
         step();
         if ((bus.D_oe | bus.busy | bus.done) != 8'h00) q++;
         if (bus.tick) nt++;
      end
      check("quiet", q, 0);
      check("tick_cnt", nt, 2);

      // V1=20: qualification latency, 1000-cycle decay, done pulse, holdoff
      load_v(0, 0, 0, 0, 0, 0, 0, 20);
      pulse(8'h01, 12);
      check("chg_oe",   bus.D_oe, 8'h00);
      check("chg_busy", bus.busy, 8'h01);
      step();
      check("rise_oe", bus.D_oe, 8'h01);
      check("rise_do", bus.D_o,  8'h01);
      run_len(0, 0, 3000, len);
      check("v20_len",  len, 1000);
      check("v20_done", bus.done, 8'h01);
      check("v20_busy", bus.busy, 8'h00);
      step();
      check("done_1cyc", bus.done, 8'h00);
      repeat (2) step();
      check("holdoff", dut.g_ch[0].u_tx.state, ST_HOLDOFF);
      step();
      check("idle", dut.g_ch[0].u_tx.state, ST_IDLE);

      // short pulse on line 3 is rejected
      pulse(8'h08, 5);
      q = 0;
      repeat (30) begin
         step();
         if (bus.D_oe[3] || bus.done[3]) q++;
      end
      check("short_pulse", q, 0);
      check("short_busy", bus.busy, 8'h00);

      // V=0 gives a single-cycle decay
      load_v(0, 0, 0, 0, 0, 0, 0, 0);
      pulse(8'h01, 12);
      step();
      check("v0_rise", bus.D_oe, 8'h01);
      step();
      check("v0_fall", bus.D_oe, 8'h00);
      check("v0_done", bus.done, 8'h01);
      repeat (10) step();

      // en low during CHARGE aborts
      bus.D_i = 8'h02;
      repeat (6) step();
      bus.en = 1'b0;
      q = 0;
      repeat (6) begin
         step();
         if (bus.D_oe[1] || bus.done[1]) q++;
      end
      bus.D_i = '0;
      repeat (6) begin
         step();
         if (bus.D_oe[1] || bus.done[1]) q++;
      end
      check("en_abort", q, 0);
      check("en_abort_busy", bus.busy, 8'h00);
      bus.en = 1'b1;
      repeat (5) step();

      // all eight lines at once, V(i+1)=i+1
      load_v(8, 7, 6, 5, 4, 3, 2, 1);
      pulse(8'hFF, 12);
      step();
      check("all_rise", bus.D_oe, 8'hFF);
      for (int i = 0; i < 8; i++) at[i] = -1;
      npulse = 0;
      for (int k = 1; k <= 450; k++) begin
         step();
         for (int i = 0; i < 8; i++) begin
            if (bus.done[i]) begin
               npulse++;
               if (at[i] < 0) at[i] = k;
            end
         end
      end
      for (int i = 0; i < 8; i++) check($sformatf("all_done%0d", i), at[i], (i + 1) * 50);
      check("all_pulses", npulse, 8);
      repeat (5) step();

      // reload during DECAY does not disturb the decay in progress
      load_v(0, 0, 30, 0, 0, 0, 0, 0);
      pulse(8'h20, 12);
      step();
      check("v6_rise", bus.D_oe, 8'h20);
      repeat (200) step();
      load_v(0, 0, 2, 0, 0, 0, 0, 0);
      run_len(5, 201, 5000, len);
      check("v6_len",  len, 1500);
      check("v6_done", bus.done, 8'h20);
      repeat (10) step();
      pulse(8'h20, 12);
      step();
      check("v6b_rise", bus.D_oe, 8'h20);
      run_len(5, 0, 5000, len);
      check("v6b_len", len, 100);
      repeat (10) step();

      // reset in the middle of DECAY on line 2
      load_v(0, 0, 0, 0, 0, 10, 0, 0);
      pulse(8'h04, 12);
      step();
      check("v3_rise", bus.D_oe, 8'h04);
      repeat (299) step();
      check("v3_mid", bus.D_oe, 8'h04);
      rst = 1'b0;
      step();
      check("rstmid_oe",    bus.D_oe, 8'h00);
      check("rstmid_done",  bus.done, 8'h00);
      check("rstmid_busy",  bus.busy, 8'h00);
      check("rstmid_state", dut.g_ch[2].u_tx.state, ST_IDLE);
      rst = 1'b1;
      q = 0;
      repeat (250) begin
         step();
         if ((bus.done | bus.D_oe) != 8'h00) q++;
      end
      check("rstmid_quiet", q, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
